// File: rtl/arb_mux.sv
// N-channel valid/ready multiplexer with a registered output stage and fixed-select or round-robin grant.
// Define ARB_MUX_COUNT_EN to add the saturating 16-bit beat_count output.
module arb_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
`ifdef ARB_MUX_COUNT_EN
  output logic [15:0]               beat_count,
`endif
  input  logic                      out_ready
);

  localparam logic [SEL_W:0] CH_N = (SEL_W+1)'(CHANNELS);

  logic [WIDTH-1:0]      r_out_data;
  logic [SEL_W-1:0]      r_out_chan;
  logic                  r_out_valid;
  logic [SEL_W-1:0]      r_rr_ptr;

  logic [WIDTH-1:0]      w_ch_data [CHANNELS];
  logic [2*CHANNELS-1:0] w_rot;
  logic [SEL_W-1:0]      w_rr_off;
  logic                  w_rr_vld;
  logic [SEL_W:0]        w_rr_sum;
  logic [SEL_W-1:0]      w_rr_grant;
  logic [SEL_W:0]        w_ptr_sum;
  logic [SEL_W-1:0]      w_next_ptr;
  logic                  w_sel_ok;
  logic [SEL_W-1:0]      w_grant;
  logic                  w_grant_vld;
  logic                  w_space;
  logic                  w_xfer;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign w_ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]  = rst_n && w_grant_vld && w_space &&
                             (w_grant == SEL_W'(gi));
    end
  endgenerate

  // Rotate valids so bit 0 is the channel at rr_ptr, then take the lowest set bit.
  assign w_rot = {in_valid, in_valid} >> r_rr_ptr;

  always_comb begin
    w_rr_off = '0;
    w_rr_vld = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_rr_off = SEL_W'(k);
        w_rr_vld = 1'b1;
      end
    end
  end

  assign w_rr_sum   = {1'b0, r_rr_ptr} + {1'b0, w_rr_off};
  assign w_rr_grant = (w_rr_sum >= CH_N) ? SEL_W'(w_rr_sum - CH_N) : SEL_W'(w_rr_sum);

  assign w_ptr_sum  = {1'b0, w_grant} + {{SEL_W{1'b0}}, 1'b1};
  assign w_next_ptr = (w_ptr_sum >= CH_N) ? '0 : SEL_W'(w_ptr_sum);

  assign w_sel_ok = (32'(sel) < 32'(CHANNELS));

  always_comb begin
    w_grant     = '0;
    w_grant_vld = 1'b0;
    if (mode) begin
      w_grant     = w_rr_grant;
      w_grant_vld = w_rr_vld;
    end else if (w_sel_ok && in_valid[sel]) begin
      // An X or out-of-range sel leaves the condition false, so no grant.
      w_grant     = sel;
      w_grant_vld = 1'b1;
    end
  end

  assign w_space = !r_out_valid || out_ready;
  assign w_xfer  = w_grant_vld && w_space;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_xfer) begin
        r_out_data  <= w_ch_data[w_grant];
        r_out_chan  <= w_grant;
        r_out_valid <= 1'b1;
        if (mode) begin
          r_rr_ptr <= w_next_ptr;
        end
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef ARB_MUX_COUNT_EN
  logic [15:0] r_beat_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_count <= '0;
    end else if (r_out_valid && out_ready && (r_beat_count != 16'hFFFF)) begin
      r_beat_count <= r_beat_count + 16'd1;
    end
  end

  assign beat_count = r_beat_count;
`endif

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule
